// File: rtl/uart_word_transmitter.sv
// -----------------------------------------------------------------------------
// uart_word_transmitter
//
// Serialises a NUM_BYTES-wide word as back-to-back UART byte frames on one TX
// line. Each frame is: start bit (0), 8 data bits LSB first, an optional parity
// bit, and STOP_BITS stop bits (1). Byte 0 (data_to_send[7:0]) goes first.
// An internal baud counter holds every bit for CLOCK_DIVIDER clock cycles, so
// the block runs directly on the system clock.
//
// The word is latched on accept, so the source may change data_to_send while
// the word is in flight. A request while busy is ignored, not queued.
//
// Optional feature:
//   `define UART_WORD_TX_PARITY_EN  -> a PARITY bit follows bit 7 of every byte,
//                                      value ^byte ^ PARITY_ODD.
//   undefined (default)             -> no parity state, PARITY_ODD is ignored.
//
// Parameters:
//   CLOCK_DIVIDER  clock cycles per UART bit (>= 2)
//   NUM_BYTES      bytes per word (>= 1)
//   STOP_BITS      stop bits per byte frame (1 or 2)
//   PARITY_ODD     0 = even parity, 1 = odd parity (parity builds only)
//
// Ports:
//   clock                      in   system clock, all logic on posedge
//   reset                      in   synchronous, active-high
//   initiate_send_signal_uart  in   request to send data_to_send
//   data_to_send               in   word to transmit, sampled on accept
//   ready                      out  idle; a request this cycle is accepted
//   busy                       out  word in flight (always ~ready)
//   uart_tx                    out  serial line, idle high
//   is_uart_send_finished      out  1-cycle pulse in the first idle cycle after
//                                   the last stop bit of a word
// -----------------------------------------------------------------------------
module uart_word_transmitter #(
  parameter int CLOCK_DIVIDER = 64,
  parameter int NUM_BYTES     = 4,
  parameter int STOP_BITS     = 1,
  parameter bit PARITY_ODD    = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   initiate_send_signal_uart,
  input  logic [8*NUM_BYTES-1:0] data_to_send,
  output logic                   ready,
  output logic                   busy,
  output logic                   uart_tx,
  output logic                   is_uart_send_finished
);

  localparam int WORD_W = 8 * NUM_BYTES;
  localparam int BAUD_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCK_DIVIDER - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);
  localparam logic [2:0]        BIT_LAST  = 3'd7;
  // The bit counter is reused to count stop bits inside STOP.
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_WORD_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Parity bit for one byte; even parity unless PARITY_ODD is set.
  function automatic logic parity_bit(input logic [7:0] byte_val);
    return (^byte_val) ^ PARITY_ODD;
  endfunction

  // Pick byte idx out of the latched word (byte 0 = bits [7:0]).
  function automatic logic [7:0] select_byte(input logic [WORD_W-1:0] word_val,
                                             input logic [BYTE_W-1:0] idx);
    logic [7:0] sel;
    sel = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx == BYTE_W'(i)) begin
        sel = word_val[8*i +: 8];
      end
    end
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and combinational next values
  // ---------------------------------------------------------------------------
  state_t              state_r;
  state_t              state_next_s;
  logic [BAUD_W-1:0]   baud_cnt_r;
  logic [BAUD_W-1:0]   baud_next_s;
  logic [2:0]          bit_cnt_r;
  logic [2:0]          bit_next_s;
  logic [BYTE_W-1:0]   byte_cnt_r;
  logic [BYTE_W-1:0]   byte_next_s;
  logic [WORD_W-1:0]   word_r;
  logic [WORD_W-1:0]   word_next_s;

  logic                tx_r;
  logic                tx_next_s;
  logic                ready_r;
  logic                busy_r;
  logic                finish_r;

  logic                accept_s;
  logic                baud_wrap_s;
  logic                last_byte_s;
  logic [7:0]          next_byte_s;

  assign accept_s    = initiate_send_signal_uart && ready_r;
  assign baud_wrap_s = (baud_cnt_r == BAUD_LAST);
  assign last_byte_s = (byte_cnt_r == BYTE_LAST);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; every non-idle state lasts whole baud periods.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_wrap_s) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_wrap_s && (bit_cnt_r == BIT_LAST)) begin
`ifdef UART_WORD_TX_PARITY_EN
          state_next_s = ST_PARITY;
`else
          state_next_s = ST_STOP;
`endif
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_wrap_s) begin
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        // Last stop bit of a byte: the next start bit follows with no gap.
        if (baud_wrap_s && (bit_cnt_r == STOP_LAST)) begin
          if (last_byte_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_START;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the baud/bit/byte counters and the latched word.
  always_comb begin
    baud_next_s = baud_cnt_r;
    bit_next_s  = bit_cnt_r;
    byte_next_s = byte_cnt_r;
    word_next_s = word_r;
    if (state_r == ST_IDLE) begin
      baud_next_s = '0;
      bit_next_s  = 3'd0;
      byte_next_s = '0;
      if (accept_s) begin
        word_next_s = data_to_send;
      end else begin
        word_next_s = word_r;
      end
    end else begin
      if (baud_wrap_s) begin
        baud_next_s = '0;
      end else begin
        baud_next_s = baud_cnt_r + 1'b1;
      end
      case (state_r)
        ST_DATA: begin
          if (baud_wrap_s) begin
            if (bit_cnt_r == BIT_LAST) begin
              bit_next_s = 3'd0;
            end else begin
              bit_next_s = bit_cnt_r + 3'd1;
            end
          end else begin
            bit_next_s = bit_cnt_r;
          end
        end
        ST_STOP: begin
          if (baud_wrap_s) begin
            if (bit_cnt_r == STOP_LAST) begin
              bit_next_s = 3'd0;
              if (last_byte_s) begin
                byte_next_s = '0;
              end else begin
                byte_next_s = byte_cnt_r + 1'b1;
              end
            end else begin
              bit_next_s = bit_cnt_r + 3'd1;
            end
          end else begin
            bit_next_s = bit_cnt_r;
          end
        end
        default: begin
          // START and PARITY never use the bit counter.
          bit_next_s = 3'd0;
        end
      endcase
    end
  end

  // Counter and word registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      word_r     <= '0;
    end else begin
      baud_cnt_r <= baud_next_s;
      bit_cnt_r  <= bit_next_s;
      byte_cnt_r <= byte_next_s;
      word_r     <= word_next_s;
    end
  end

  // FSM output decode. It looks at the next state and next counters so the
  // registered line changes together with the state (start bit in the cycle
  // right after accept).
  always_comb begin
    next_byte_s = select_byte(word_next_s, byte_next_s);
    tx_next_s   = 1'b1;
    case (state_next_s)
      ST_IDLE:   tx_next_s = 1'b1;
      ST_START:  tx_next_s = 1'b0;
      ST_DATA:   tx_next_s = next_byte_s[bit_next_s];
`ifdef UART_WORD_TX_PARITY_EN
      ST_PARITY: tx_next_s = parity_bit(next_byte_s);
`endif
      ST_STOP:   tx_next_s = 1'b1;
      default:   tx_next_s = 1'b1;
    endcase
  end

  // Registered outputs; the finish pulse marks the step back into IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_r     <= 1'b1;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      finish_r <= 1'b0;
    end else begin
      tx_r     <= tx_next_s;
      ready_r  <= (state_next_s == ST_IDLE);
      busy_r   <= (state_next_s != ST_IDLE);
      finish_r <= (state_r != ST_IDLE) && (state_next_s == ST_IDLE);
    end
  end

  assign uart_tx               = tx_r;
  assign ready                 = ready_r;
  assign busy                  = busy_r;
  assign is_uart_send_finished = finish_r;

endmodule

// File: tb/tb_uart_word_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_word_transmitter
//
// Directed bench for uart_word_transmitter with CLOCK_DIVIDER=4:
//   dut_a : NUM_BYTES=1, PARITY_ODD=0
//   dut_b : NUM_BYTES=4, PARITY_ODD=0
//   dut_c : NUM_BYTES=1, PARITY_ODD=1
// Cycle 0 is the cycle in which the request is accepted; the line is sampled on
// the falling edge of cycles 1..n and stored as wave[i-1]. Idle after a word
// is high, so unsampled wave bits are preset to 1.
// -----------------------------------------------------------------------------
module tb_uart_word_transmitter;

  localparam int DIV = 4;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = 10 + PB;       // bits per byte frame (1 stop bit)
  localparam int L     = FRAME * DIV;   // cycles per byte frame

  logic        clock = 1'b0;
  logic [2:0]  rst   = 3'b111;
  logic [2:0]  req   = 3'b000;
  logic [7:0]  data_a = 8'h00;
  logic [31:0] data_b = 32'h0;
  logic [7:0]  data_c = 8'h00;
  wire  [2:0]  tx_w;
  wire  [2:0]  ready_w;
  wire  [2:0]  busy_w;
  wire  [2:0]  fin_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  uart_word_transmitter #(.CLOCK_DIVIDER(DIV), .NUM_BYTES(1), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut_a (
    .clock(clock), .reset(rst[0]), .initiate_send_signal_uart(req[0]), .data_to_send(data_a),
    .ready(ready_w[0]), .busy(busy_w[0]), .uart_tx(tx_w[0]), .is_uart_send_finished(fin_w[0]));

  uart_word_transmitter #(.CLOCK_DIVIDER(DIV), .NUM_BYTES(4), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut_b (
    .clock(clock), .reset(rst[1]), .initiate_send_signal_uart(req[1]), .data_to_send(data_b),
    .ready(ready_w[1]), .busy(busy_w[1]), .uart_tx(tx_w[1]), .is_uart_send_finished(fin_w[1]));

  uart_word_transmitter #(.CLOCK_DIVIDER(DIV), .NUM_BYTES(1), .STOP_BITS(1), .PARITY_ODD(1'b1)) dut_c (
    .clock(clock), .reset(rst[2]), .initiate_send_signal_uart(req[2]), .data_to_send(data_c),
    .ready(ready_w[2]), .busy(busy_w[2]), .uart_tx(tx_w[2]), .is_uart_send_finished(fin_w[2]));

  // Count one comparison and report it if observed differs from expected.
  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One byte frame, first-sent bit at index 0: start, data LSB first, [parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic odd);
`ifdef UART_WORD_TX_PARITY_EN
    return {1'b1, (^b) ^ odd, b, 1'b0};
`else
    return {odd, 1'b1, b, 1'b0};      // bit 10 is padding beyond FRAME
`endif
  endfunction

  // Expected line per cycle for a whole word, idle high afterwards.
  function automatic logic [255:0] word_wave(input logic [31:0] w, input int nb, input logic odd);
    logic [255:0] r;
    logic [10:0]  f;
    int           pos;
    r   = '1;
    pos = 0;
    for (int k = 0; k < nb; k++) begin
      f = frame_of(w[8*k +: 8], odd);
      for (int j = 0; j < FRAME; j++) begin
        for (int c = 0; c < DIV; c++) begin
          r[pos] = f[j];
          pos++;
        end
      end
    end
    return r;
  endfunction

  // Sample cycles 1..n of DUT id; record finish pulses, first ready cycle and
  // any cycle where busy is not the inverse of ready.
  task automatic capture(input int id, input int n, output logic [255:0] wave,
                         output int fin_cnt, output int fin_first,
                         output int rdy_first, output int busy_bad);
    wave      = '1;
    fin_cnt   = 0;
    fin_first = -1;
    rdy_first = -1;
    busy_bad  = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      wave[i-1] = tx_w[id];
      if (fin_w[id] === 1'b1) begin
        fin_cnt++;
        if (fin_first < 0) fin_first = i;
      end
      if (ready_w[id] === 1'b1 && rdy_first < 0) rdy_first = i;
      if (busy_w[id] === ready_w[id]) busy_bad++;
    end
  endtask

  // One-cycle request on DUT id; returns just after the accepting edge.
  task automatic launch(input int id);
    @(negedge clock);
    check_eq($sformatf("ready_before_req%0d", id), ready_w[id], 1'b1);
    req[id] = 1'b1;
    @(posedge clock);
    #1;
    req[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wave;
    logic [255:0] exp;
    logic [255:0] mask;
    int fc, ff, rf, bb;

    // Reset values while reset is held for 5 cycles.
    rst = 3'b111;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check_eq("rst_tx",    tx_w,    3'b111);
    check_eq("rst_ready", ready_w, 3'b111);
    check_eq("rst_busy",  busy_w,  3'b000);
    check_eq("rst_fin",   fin_w,   3'b000);
    rst = 3'b000;

    // Single byte A5: start 1-4, bits 1,0,1,0,0,1,0,1, stop, finish at L+1.
    data_a = 8'hA5;
    launch(0);
    capture(0, L + 4, wave, fc, ff, rf, bb);
    check_eq("a5_wave",      wave, word_wave(32'h0000_00A5, 1, 1'b0));
    check_eq("a5_start_low", wave[3:0], 4'h0);
    check_eq("a5_fin_cnt",   fc, 1);
    check_eq("a5_fin_at",    ff, L + 1);
    check_eq("a5_ready_at",  rf, L + 1);
    check_eq("a5_busy_inv",  bb, 0);

`ifdef UART_WORD_TX_PARITY_EN
    // 8'h07 has three ones: even parity bit 1, odd parity bit 0.
    data_a = 8'h07;
    launch(0);
    capture(0, L + 4, wave, fc, ff, rf, bb);
    check_eq("par_even_wave", wave, word_wave(32'h0000_0007, 1, 1'b0));
    check_eq("par_even_bit",  wave[9*DIV], 1'b1);
    check_eq("par_even_fin",  ff, 45);
    data_c = 8'h07;
    launch(2);
    capture(2, L + 4, wave, fc, ff, rf, bb);
    check_eq("par_odd_wave",  wave, word_wave(32'h0000_0007, 1, 1'b1));
    check_eq("par_odd_bit",   wave[9*DIV], 1'b0);
`endif

    // Four-byte word: bytes 11,22,33,44 back to back, one finish pulse.
    data_b = 32'h4433_2211;
    launch(1);
    capture(1, 4*L + 4, wave, fc, ff, rf, bb);
    check_eq("w4_wave",     wave, word_wave(32'h4433_2211, 4, 1'b0));
    check_eq("w4_fin_cnt",  fc, 1);
    check_eq("w4_fin_at",   ff, 4*L + 1);
    check_eq("w4_busy_inv", bb, 0);

    // Data changed after accept, request held: original word, then a second
    // word (data 00) starting 2 cycles after the first word's last stop cycle.
    data_c = 8'h3C;
    @(negedge clock);
    req[2] = 1'b1;
    @(posedge clock);
    #1;
    data_c = 8'h00;
    capture(2, 2*L + 2, wave, fc, ff, rf, bb);
    req[2] = 1'b0;
    mask = (256'd1 << (L + 1)) - 256'd1;
    exp  = (word_wave(32'h0, 1, 1'b1) << (L + 1)) | (word_wave(32'h0000_003C, 1, 1'b1) & mask);
    check_eq("hold_wave",      wave, exp);
    check_eq("hold_idle_cyc",  wave[L], 1'b1);
    check_eq("hold_2nd_start", wave[L+1], 1'b0);
    check_eq("hold_fin_cnt",   fc, 2);
    check_eq("hold_fin_at",    ff, L + 1);
    capture(2, 4, wave, fc, ff, rf, bb);
    check_eq("hold_no_third",  wave[3:0], 4'hF);

    // Reset during byte 2, held 5 cycles: line idles, no finish pulse.
    data_b = 32'hDEAD_BEEF;
    launch(1);
    repeat (2*L + 10) @(negedge clock);
    rst[1] = 1'b1;
    @(negedge clock);
    check_eq("mid_rst_tx",    tx_w[1],    1'b1);
    check_eq("mid_rst_ready", ready_w[1], 1'b1);
    check_eq("mid_rst_busy",  busy_w[1],  1'b0);
    check_eq("mid_rst_fin",   fin_w[1],   1'b0);
    repeat (4) @(negedge clock);
    rst[1] = 1'b0;
    capture(1, 4*L, wave, fc, ff, rf, bb);
    check_eq("post_rst_idle",  wave, {256{1'b1}});
    check_eq("post_rst_nofin", fc, 0);
    check_eq("post_rst_ready", rf, 1);

    // Fresh word after the abandoned one.
    data_b = 32'h0F1E_2D3C;
    launch(1);
    capture(1, 4*L + 4, wave, fc, ff, rf, bb);
    check_eq("fresh_wave",    wave, word_wave(32'h0F1E_2D3C, 4, 1'b0));
    check_eq("fresh_fin_cnt", fc, 1);
    check_eq("fresh_fin_at",  ff, 4*L + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
